// File: rtl/ibus_arbiter_pkg.sv
// Shared types and helpers for the internal-bus arbiter.
// Master indices, arbiter states, the bus payload struct and index helpers.
package ibus_arbiter_pkg;

  localparam int unsigned IBA_NM = 3;
  localparam int unsigned IBA_IW = $clog2(IBA_NM);
  localparam int unsigned IBA_AW = 32;
  localparam int unsigned IBA_DW = 32;
  localparam int unsigned IBA_BW = 4;

  typedef enum logic [IBA_IW-1:0] {IBM_DMAC, IBM_DATA, IBM_IFETCH} ibus_master_e;

  typedef enum logic {IBA_IDLE, IBA_OWN} ibus_arb_state_e;

  typedef struct packed {
    logic [IBA_AW-1:0] a;
    logic [IBA_DW-1:0] di;
    logic [IBA_BW-1:0] ba;
    logic              we;
    logic              req;
    logic              lock;
  } ibus_req_t;

  // Index of the set bit in a one-hot master vector.
  function automatic logic [IBA_IW-1:0] onehot_idx(input logic [IBA_NM-1:0] oh);
    logic [IBA_IW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < IBA_NM; i++) begin
      if (oh[i]) idx = IBA_IW'(i);
    end
    return idx;
  endfunction

  // Successor index, wrapping the last master back to 0.
  function automatic logic [IBA_IW-1:0] next_idx(input logic [IBA_IW-1:0] i);
    logic [IBA_IW-1:0] n;
    if (i == IBA_IW'(IBA_NM - 1)) n = '0;
    else n = i + IBA_IW'(1);
    return n;
  endfunction

endpackage

// File: rtl/ibus_arb_pick.sv
// Rotating priority encoder: first requester at or after the start index wins.
// Start is ptr in round-robin mode, 0 in fixed mode.
module ibus_arb_pick
  import ibus_arbiter_pkg::*;
(
  input  logic [IBA_NM-1:0] req,
  input  logic [IBA_IW-1:0] ptr,
  input  logic              rr_mode,
  output logic [IBA_NM-1:0] win,
  output logic              valid
);

  localparam int unsigned SW = IBA_IW + 1;

  logic [IBA_IW-1:0] start;
  logic [SW-1:0]     sum;
  logic [IBA_IW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    start = rr_mode ? ptr : '0;
    for (int unsigned k = 0; k < IBA_NM; k++) begin
      sum = SW'(start) + SW'(k);
      if (sum >= SW'(IBA_NM)) sum = sum - SW'(IBA_NM);
      idx = IBA_IW'(sum);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibus_arbiter.sv
// Three-master internal-bus arbiter: fixed or round-robin priority, locked
// sequences, back-to-back handover; slave-side signals are muxed combinationally.
module ibus_arbiter
  import ibus_arbiter_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ce_r,
  input  logic                           res_n,
  input  logic                           rr_mode,
  input  logic [IBA_NM-1:0][IBA_AW-1:0]  m_a,
  input  logic [IBA_NM-1:0][IBA_DW-1:0]  m_di,
  input  logic [IBA_NM-1:0][IBA_BW-1:0]  m_ba,
  input  logic [IBA_NM-1:0]              m_we,
  input  logic [IBA_NM-1:0]              m_req,
  input  logic [IBA_NM-1:0]              m_lock,
  output logic [IBA_NM-1:0]              m_busy,
  output logic [IBA_DW-1:0]              m_do,
  output logic [IBA_NM-1:0]              grant,
  output logic [IBA_AW-1:0]              ibus_a,
  output logic [IBA_DW-1:0]              ibus_di,
  output logic [IBA_BW-1:0]              ibus_ba,
  output logic                           ibus_we,
  output logic                           ibus_req,
  output logic                           ibus_lock,
  input  logic [IBA_DW-1:0]              ibus_do,
  input  logic                           ibus_busy
);

  ibus_arb_state_e   state;
  logic [IBA_IW-1:0] owner;
  logic [IBA_IW-1:0] ptr;
  logic [IBA_IW-1:0] win_idx;
  logic [IBA_NM-1:0] win;
  logic              win_valid;
  logic              owned;
  logic              release_c;
  logic              arb_c;
  ibus_req_t         sel;

  assign owned     = (state == IBA_OWN);
  assign release_c = owned && !m_req[owner] && !m_lock[owner] && !ibus_busy;
  assign arb_c     = !owned || release_c;
  assign win_idx   = onehot_idx(win);

  ibus_arb_pick u_pick (
    .req     (m_req),
    .ptr     (ptr),
    .rr_mode (rr_mode),
    .win     (win),
    .valid   (win_valid)
  );

  // Ownership state; a release re-arbitrates on the same enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IBA_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else if (ce_r) begin
      if (!res_n) begin
        state <= IBA_IDLE;
        grant <= '0;
        owner <= '0;
        ptr   <= '0;
      end else if (arb_c) begin
        if (win_valid) begin
          state <= IBA_OWN;
          grant <= win;
          owner <= win_idx;
          ptr   <= next_idx(win_idx);
        end else begin
          state <= IBA_IDLE;
          grant <= '0;
        end
      end
    end
  end

  // Owner's request goes to the slave; everyone else sees its own request as busy.
  always_comb begin
    sel    = '0;
    m_busy = m_req;
    if (owned) begin
      sel.a         = m_a[owner];
      sel.di        = m_di[owner];
      sel.ba        = m_ba[owner];
      sel.we        = m_we[owner];
      sel.req       = m_req[owner];
      sel.lock      = m_lock[owner];
      m_busy[owner] = ibus_busy;
    end
  end

  assign ibus_a    = sel.a;
  assign ibus_di   = sel.di;
  assign ibus_ba   = sel.ba;
  assign ibus_we   = sel.we;
  assign ibus_req  = sel.req;
  assign ibus_lock = sel.lock;
  assign m_do      = ibus_do;

endmodule

// File: tb/tb_ibus_arbiter.sv
// Self-checking bench for ibus_arbiter: directed scenarios plus randomized
// traffic against a behavioural ownership model (owner index, RR pointer).
module tb_ibus_arbiter;

  logic             clk;
  logic             rst_n;
  logic             ce_r;
  logic             res_n;
  logic             rr_mode;
  logic [2:0][31:0] m_a;
  logic [2:0][31:0] m_di;
  logic [2:0][3:0]  m_ba;
  logic [2:0]       m_we;
  logic [2:0]       m_req;
  logic [2:0]       m_lock;
  logic [2:0]       m_busy;
  logic [31:0]      m_do;
  logic [2:0]       grant;
  logic [31:0]      ibus_a;
  logic [31:0]      ibus_di;
  logic [3:0]       ibus_ba;
  logic             ibus_we;
  logic             ibus_req;
  logic             ibus_lock;
  logic [31:0]      ibus_do;
  logic             ibus_busy;

  int checks = 0;
  int errors = 0;
  int mo = -1;
  int mp = 0;

  ibus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ce_r(ce_r), .res_n(res_n), .rr_mode(rr_mode),
    .m_a(m_a), .m_di(m_di), .m_ba(m_ba), .m_we(m_we), .m_req(m_req),
    .m_lock(m_lock), .m_busy(m_busy), .m_do(m_do), .grant(grant),
    .ibus_a(ibus_a), .ibus_di(ibus_di), .ibus_ba(ibus_ba), .ibus_we(ibus_we),
    .ibus_req(ibus_req), .ibus_lock(ibus_lock), .ibus_do(ibus_do),
    .ibus_busy(ibus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    int w;
    int st;
    if (!rst_n) begin
      mo = -1; mp = 0;
    end else if (ce_r) begin
      if (!res_n) begin
        mo = -1; mp = 0;
      end else if (mo < 0 || (!m_req[2'(mo)] && !m_lock[2'(mo)] && !ibus_busy)) begin
        w  = -1;
        st = rr_mode ? mp : 0;
        for (int k = 0; k < 3; k++)
          if (w < 0 && m_req[2'((st + k) % 3)]) w = (st + k) % 3;
        mo = w;
        if (w >= 0) mp = (w + 1) % 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_grant();
    return (mo < 0) ? 3'b000 : 3'(1 << mo);
  endfunction

  function automatic logic [2:0] exp_busy();
    logic [2:0] b;
    b = m_req;
    if (mo >= 0) b[2'(mo)] = ibus_busy;
    return b;
  endfunction

  task automatic go_idle();
    m_req = '0; m_lock = '0; m_we = '0; ibus_busy = 1'b0; ce_r = 1'b1; res_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce_r = 1'b1; res_n = 1'b1; rr_mode = 1'b0;
    m_a = '0; m_di = '0; m_ba = '0; m_we = '0; m_req = '0; m_lock = '0;
    ibus_do = '0; ibus_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL reset_ibus_req: got %b expected 0", ibus_req); end
    checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", m_busy); end
  endtask

  task automatic test_async_reset();
    m_req = 3'b001;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL arst_pre_grant: got %b expected 001", grant); end
    rst_n = 1'b0; mo = -1; mp = 0;
    #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL arst_grant: got %b expected 000", grant); end
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL arst_ibus_req: got %b expected 0", ibus_req); end
    rst_n = 1'b1; m_req = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    rr_mode = 1'b0; m_req = 3'b111;
    #1;
    checks++; if (m_busy !== 3'b111) begin errors++; $display("FAIL fixed_wait_busy: got %b expected 111", m_busy); end
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL fixed_first: got %b expected 001", grant); end
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL fixed_ibus_req: got %b expected 1", ibus_req); end
    m_req = 3'b110;
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL fixed_second: got %b expected 010", grant); end
    m_req = 3'b100;
    tick();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL fixed_third: got %b expected 100", grant); end
    go_idle();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL fixed_idle: got %b expected 000", grant); end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL soft_reset_grant: got %b expected 000", grant); end
    rr_mode = 1'b1; m_req = 3'b111;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rr_0: got %b expected 001", grant); end
    for (int j = 1; j < 6; j++) begin
      m_req = 3'b111 & ~3'(1 << order[j-1]);
      tick();
      checks++;
      if (grant !== 3'(1 << order[j])) begin
        errors++; $display("FAIL rr_%0d: got %b expected %b", j, grant, 3'(1 << order[j]));
      end
    end
    go_idle();
    rr_mode = 1'b0;
  endtask

  task automatic test_busy_hold();
    m_req = 3'b001;
    tick();
    m_req = 3'b010; ibus_busy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL busy_hold_%0d: got %b expected 001", j, grant); end
      checks++; if (m_busy !== 3'b011) begin errors++; $display("FAIL busy_stall_%0d: got %b expected 011", j, m_busy); end
    end
    ibus_busy = 1'b0;
    #1;
    checks++; if (m_busy[1] !== 1'b1) begin errors++; $display("FAIL busy_data_wait: got %b expected 1", m_busy[1]); end
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL busy_handover: got %b expected 010", grant); end
    go_idle();
  endtask

  task automatic test_lock();
    m_a[1] = 32'h0600_0000; m_we = 3'b000; m_req = 3'b010; m_lock = 3'b010;
    tick();
    checks++; if (grant !== 3'b010 || ibus_lock !== 1'b1) begin
      errors++; $display("FAIL lock_read: got grant %b lock %b expected 010 1", grant, ibus_lock); end
    m_req = 3'b001;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++; if (grant !== 3'b010 || ibus_lock !== 1'b1 || ibus_req !== 1'b0) begin
        errors++; $display("FAIL lock_gap_%0d: got grant %b lock %b req %b expected 010 1 0",
                           j, grant, ibus_lock, ibus_req); end
    end
    m_req = 3'b011; m_we = 3'b010;
    tick();
    checks++; if (grant !== 3'b010 || ibus_we !== 1'b1 || ibus_a !== 32'h0600_0000) begin
      errors++; $display("FAIL lock_write: got grant %b we %b a %h expected 010 1 06000000",
                         grant, ibus_we, ibus_a); end
    m_req = 3'b001; m_lock = 3'b000; m_we = 3'b000;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lock_release: got %b expected 001", grant); end
    go_idle();
  endtask

  task automatic test_datapath();
    m_req = 3'b001; m_we = 3'b001;
    m_a[0] = 32'h2000_0004; m_ba[0] = 4'hF; m_di[0] = 32'hDEAD_BEEF;
    tick();
    checks++; if (ibus_a !== 32'h2000_0004 || ibus_ba !== 4'hF || ibus_di !== 32'hDEAD_BEEF || ibus_we !== 1'b1) begin
      errors++; $display("FAIL datapath_fwd: got a %h ba %h di %h we %b expected 20000004 f deadbeef 1",
                         ibus_a, ibus_ba, ibus_di, ibus_we); end
    ibus_do = 32'h1234_5678; m_a[1] = 32'hFFFF_0000; m_a[0] = 32'h2000_0008;
    #1;
    checks++; if (m_do !== 32'h1234_5678) begin errors++; $display("FAIL datapath_do: got %h expected 12345678", m_do); end
    checks++; if (ibus_a !== 32'h2000_0008) begin errors++; $display("FAIL datapath_same_cycle: got %h expected 20000008", ibus_a); end
    go_idle();
  endtask

  task automatic test_glitch_and_ce();
    m_req = 3'b100;
    #3;
    m_req = 3'b000;
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL glitch_grant: got %b expected 000", grant); end
    ce_r = 1'b0; m_req = 3'b100;
    tick();
    checks++; if (grant !== 3'b000 || m_busy !== 3'b100) begin
      errors++; $display("FAIL ce_hold: got grant %b busy %b expected 000 100", grant, m_busy); end
    ce_r = 1'b1;
    tick();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL ce_grant: got %b expected 100", grant); end
    go_idle();
  endtask

  task automatic test_random();
    logic [31:0] ea;
    logic        er;
    logic        el;
    for (int n = 0; n < 600; n++) begin
      ce_r      = ($urandom % 4) != 0;
      res_n     = ($urandom % 60) != 0;
      if (($urandom % 40) == 0) rr_mode = ~rr_mode;
      m_req     = 3'($urandom);
      m_lock    = {($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0};
      m_we      = 3'($urandom);
      ibus_busy = ($urandom % 3) == 0;
      for (int i = 0; i < 3; i++) m_a[i] = $urandom;
      ibus_do   = $urandom;
      tick();
      ea = (mo < 0) ? 32'h0 : m_a[2'(mo)];
      er = (mo < 0) ? 1'b0 : m_req[2'(mo)];
      el = (mo < 0) ? 1'b0 : m_lock[2'(mo)];
      checks++; if (grant !== exp_grant()) begin
        errors++; $display("FAIL rand_grant_%0d: got %b expected %b", n, grant, exp_grant()); end
      checks++; if (m_busy !== exp_busy()) begin
        errors++; $display("FAIL rand_busy_%0d: got %b expected %b", n, m_busy, exp_busy()); end
      checks++; if (ibus_a !== ea || ibus_req !== er || ibus_lock !== el || m_do !== ibus_do) begin
        errors++; $display("FAIL rand_bus_%0d: got a %h req %b lock %b expected %h %b %b",
                           n, ibus_a, ibus_req, ibus_lock, ea, er, el); end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_fixed_priority();
    test_round_robin();
    test_busy_hold();
    test_lock();
    test_datapath();
    test_glitch_and_ce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_arbiter.md
# ibus_arbiter

Arbitrates the CPU internal bus between three masters (DMAC, CPU data port, CPU instruction fetch) ahead of the bus state controller. Exactly one master at a time is forwarded to the single downstream IBUS slave port. All other requesters are held off with BUSY. Supports fixed or round-robin priority and locked read-modify-write sequences (TAS).

## Interface
- NM, 3, number of masters (index 0 = DMAC, 1 = CPU data, 2 = CPU ifetch)
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; all state updates occur on CLK edges with CE_R=1
- RES_N  in  1  synchronous soft reset (applied on CE_R); same effect as RST_N
- RR_MODE  in  1  0 = fixed priority 0>1>2, 1 = round-robin
- M_A[i]  in  32  master address
- M_DI[i]  in  32  master write data
- M_BA[i]  in  4  master byte enables
- M_WE[i]  in  1  master write
- M_REQ[i]  in  1  master request
- M_LOCK[i]  in  1  master holds the bus past the end of the request
- M_BUSY[i]  out  1  stall to master
- M_DO  out  32  read data, broadcast to all masters
- GRANT  out  NM  one-hot owner, registered
- IBUS_A/DI/BA/WE/REQ/LOCK  out  32/32/4/1/1/1  to slave
- IBUS_DO  in  32  slave read data
- IBUS_BUSY  in  1  slave stall

## Operation
- States: IDLE (GRANT=0) and OWN (GRANT one-hot, OWNER index held).
- IDLE, on CE_R, if any M_REQ is high: select a winner, set GRANT, go to OWN.
- Fixed mode: lowest index wins.
- RR mode: search starts at PTR. PTR resets to 0; on each new grant, PTR = winner+1 mod NM.
- OWN:
  - Forward the owner's A/DI/BA/WE/REQ/LOCK to IBUS_*. Non-owned inputs are ignored.
  - Release condition, on CE_R: M_REQ[owner]=0, M_LOCK[owner]=0 and IBUS_BUSY=0.
  - On release, if another request is pending, re-arbitrate in the same CE_R (back-to-back handover, no IDLE cycle). Otherwise go to IDLE.
- No preemption: a higher-priority request never displaces the owner.
- Lock: while M_LOCK[owner]=1, ownership is held even with M_REQ low. IBUS_LOCK mirrors it.
- Idle outputs: IBUS_REQ=0, IBUS_WE=0, IBUS_LOCK=0, IBUS_BA=0; IBUS_A/DI=0.
- M_BUSY[i]:
  - = M_REQ[i] when i is not the owner (including in IDLE).
  - = IBUS_BUSY when i is the owner.
- M_DO = IBUS_DO unconditionally.
- RST_N/RES_N, including mid-transaction: GRANT=0, state IDLE, PTR=0. The IBUS_* outputs fall to their idle values immediately; the slave is reset by the same RES_N.

## Timing
- Grant latency: a request sampled at CE_R edge n gives GRANT valid after edge n. IBUS_REQ rises combinationally in the same cycle.
- The requester sees M_BUSY=1 for at least one CE_R period before first service.
- IBUS_* are combinational from GRANT and the owner's inputs: no added pipeline stage and no data latency through the arbiter.
- Handover: the last owner cycle and the new owner's first IBUS_REQ are adjacent CE_R periods.
- Simultaneous events:
  - A request arriving on the same edge as a release is arbitrated on that edge.
  - Requests from all masters on one edge are resolved by the priority rule.
  - A request that rises and falls between CE_R edges is never granted.

## Structure
- CPU_PKG additions:
  - IBusMaster_t enum {IBM_DMAC, IBM_DATA, IBM_IFETCH}
  - IBusArbState_t {IBA_IDLE, IBA_OWN}
  - constant IBA_NM = 3
- Sub-module ibus_arb_pick: combinational rotating priority encoder. Inputs REQ[NM], PTR, RR_MODE; outputs a one-hot WIN and a VALID flag.
- The top level holds the state register, OWNER, PTR and the output muxes.

## Test plan
- Reset, then no requests → GRANT=000, IBUS_REQ=0, all M_BUSY=0. Assert RST_N mid-ownership → GRANT=000 immediately.
- Fixed mode, M_REQ=111 on the same edge → GRANT=001. After DMAC drops REQ, GRANT=010 on the next CE_R, then 100. No IDLE gap between grants.
- RR mode, all three requesting continuously and each releasing after one access → grant order 0,1,2,0,1,2. PTR wraps 2→0.
- DMAC owns, M_REQ[0]=0 while IBUS_BUSY=1 → GRANT held until IBUS_BUSY=0. The CPU data request sees M_BUSY[1]=1 throughout.
- CPU data owns with M_LOCK[1]=1 (TAS at A=0x0600_0000): REQ drops between the read and the write while DMAC requests → GRANT stays 010 and IBUS_LOCK=1. DMAC is granted only after LOCK=0.
- Owner M_WE=1, A=0x2000_0004, BA=1111, DI=0xDEADBEEF → IBUS_* equal these values in the same cycle. IBUS_DO=0x12345678 → M_DO=0x12345678.
